multi_port_rob: RTL and testbench
=================================

// Module: multi_port_rob
// PURPOSE
//  Parametrised in-order reorder buffer, next generation of the single-CDB ROB.
//  Allocates one entry per cycle from dispatch and accepts results from CDB_PORTS
//  completion buses (ALU/BR/LSQ) in the same cycle. Retires the head entry
//  in order to the regfile under a ready handshake.
//  Supports partial flush: squashes all entries younger than a branch tag.
// PARAMETERS
//  WIDTH     32  data/PC width
//  SIZE      16  entry count; power of two, >=2
//  CDB_PORTS 3   number of completion buses
//  TAG_W     $clog2(SIZE)  tag width (derived, do not override)
// PORTS
//  clk          in   1                  clock, all state on posedge
//  rst          in   1                  synchronous reset, active-high
//  alloc_valid  in   1                  dispatch requests an entry
//  alloc_pc     in   WIDTH              PC of dispatched instr
//  alloc_rd     in   5                  destination register
//  alloc_ready  out  1                  entry available this cycle
//  alloc_tag    out  TAG_W              tag the current alloc receives (=tail)
//  cdb_valid    in   CDB_PORTS          per-port completion strobe
//  cdb_tag      in   CDB_PORTS*TAG_W    per-port tag, port p at [p*TAG_W +: TAG_W]
//  cdb_data     in   CDB_PORTS*WIDTH    per-port result
//  commit_valid out  1                  head entry done, presented for retire
//  commit_ready in   1                  regfile accepts commit
//  commit_tag   out  TAG_W              head tag
//  commit_rd    out  5                  head rd
//  commit_data  out  WIDTH              head result
//  commit_pc    out  WIDTH              head PC
//  flush        in   1                  squash younger than flush_tag
//  flush_tag    in   TAG_W              oldest surviving tag
//  count        out  TAG_W+1            occupied entries, 0..SIZE
// BEHAVIOUR
//  - State: head, tail (TAG_W, wrap mod SIZE), count; per entry valid, rdy, rd, pc, data.
//  - Full/empty from count only: full = count==SIZE, empty = count==0.
//  - Reset: head=tail=count=0; all valid/rdy/data/pc/rd = 0. alloc_ready=1, alloc_tag=0,
//    commit_valid=0, commit_* =0, count=0. Reset overrides every other event same edge.
//  - alloc_ready = !full && !flush. Full-with-commit does NOT free a slot that cycle.
//  - Alloc fires on alloc_valid&&alloc_ready: entry[tail] <= {valid=1,rdy=0,pc,rd,data=0};
//    tail <= tail+1. alloc_tag is combinational = tail.
//  - Completion, port p with cdb_valid[p]: if entry[cdb_tag].valid -> data<=cdb_data,
//    rdy<=1; strobes to invalid entries are ignored. Same tag on two ports: highest
//    index p wins. CDB hit on tail being allocated same cycle is ignored.
//  - Commit: commit_valid = !empty && entry[head].valid && entry[head].rdy (combinational).
//    commit_* driven from entry[head], 0 when empty. Fires on commit_valid&&commit_ready:
//    entry[head] cleared to 0, head <= head+1. Result completing at head is visible
//    one cycle later (no CDB->commit bypass; latency alloc->earliest commit = 2 cycles).
//  - Flush, only honoured if flush_tag is occupied (offset flush_tag-head mod SIZE < count):
//    entries at offsets > offset(flush_tag) cleared; tail <= flush_tag+1;
//    count <= offset+1, minus 1 if commit fires same cycle. Same-cycle alloc blocked
//    (alloc_ready=0); CDB writes to squashed tags dropped; CDB writes to survivors apply.
//    Flush with unoccupied flush_tag: no effect except alloc blocked that cycle.
//  - count update otherwise: +1 on alloc, -1 on commit, unchanged if both.
//  - Wrap: pointers increment mod SIZE; offset arithmetic in TAG_W bits unsigned.
// TESTING
//  1 rst; alloc 16 entries (SIZE=16) -> tags 0..15, count=16, alloc_ready=0 on 17th.
//  2 CDB port0 tag3 data 0xAA, port2 tag3 data 0xBB same cycle -> entry3 data=0xBB.
//  3 complete tag0 with commit_ready=0 -> commit_valid held, count unchanged; raise
//    ready -> one commit of tag0, head=1.
//  4 fill, commit 4, alloc 4 -> tags 0..3 reused, count=16, in-order commit 4..15,0..3.
//  5 8 entries head=0, flush tag2 with commit of tag0 same cycle -> tail=3, count=2,
//    CDB to tag5 same cycle ignored.
//  6 rst asserted mid-fill with CDB and commit active -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/multi_port_rob.sv
// In-order reorder buffer: one dispatch allocation per cycle, CDB_PORTS completion
// buses, in-order retire under a ready handshake, and partial flush of younger entries.
module multi_port_rob #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SIZE      = 16,
    parameter int unsigned CDB_PORTS = 3,
    parameter int unsigned TAG_W     = $clog2(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [WIDTH-1:0]           alloc_pc,
    input  logic [4:0]                 alloc_rd,
    output logic                       alloc_ready,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*WIDTH-1:0] cdb_data,
    output logic                       commit_valid,
    input  logic                       commit_ready,
    output logic [TAG_W-1:0]           commit_tag,
    output logic [4:0]                 commit_rd,
    output logic [WIDTH-1:0]           commit_data,
    output logic [WIDTH-1:0]           commit_pc,
    input  logic                       flush,
    input  logic [TAG_W-1:0]           flush_tag,
    output logic [TAG_W:0]             count
);

    localparam int unsigned      CNT_W    = TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SIZE);

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_valid [SIZE];
    logic             r_rdy   [SIZE];
    logic [4:0]       r_rd    [SIZE];
    logic [WIDTH-1:0] r_pc    [SIZE];
    logic [WIDTH-1:0] r_data  [SIZE];

    logic             w_full;
    logic             w_empty;
    logic             w_alloc;
    logic             w_commit;
    logic [TAG_W-1:0] w_flush_off;
    logic             w_flush_hit;
    logic             w_squash   [SIZE];
    logic             w_cdb_hit  [SIZE];
    logic [WIDTH-1:0] w_cdb_data [SIZE];

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign alloc_ready = !w_full && !flush;
    assign alloc_tag   = r_tail;
    assign w_alloc     = alloc_valid && alloc_ready;

    assign commit_valid = !w_empty && r_valid[r_head] && r_rdy[r_head];
    assign w_commit     = commit_valid && commit_ready;
    assign commit_tag   = w_empty ? '0 : r_head;
    assign commit_rd    = w_empty ? '0 : r_rd[r_head];
    assign commit_data  = w_empty ? '0 : r_data[r_head];
    assign commit_pc    = w_empty ? '0 : r_pc[r_head];
    assign count        = r_count;

    // Flush only counts when flush_tag sits inside the occupied window.
    assign w_flush_off = flush_tag - r_head;
    assign w_flush_hit = flush && (CNT_W'(w_flush_off) < r_count);

    always_comb begin
        for (int i = 0; i < int'(SIZE); i++) begin
            w_squash[i] = w_flush_hit && (TAG_W'(TAG_W'(i) - r_head) > w_flush_off);
        end
    end

    // Per-entry CDB match; a higher port index overrides a lower one.
    always_comb begin
        for (int i = 0; i < int'(SIZE); i++) begin
            w_cdb_hit[i]  = 1'b0;
            w_cdb_data[i] = '0;
            for (int p = 0; p < int'(CDB_PORTS); p++) begin
                if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(i))) begin
                    w_cdb_hit[i]  = 1'b1;
                    w_cdb_data[i] = cdb_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(SIZE); i++) begin
                r_valid[i] <= 1'b0;
                r_rdy[i]   <= 1'b0;
                r_rd[i]    <= '0;
                r_pc[i]    <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (w_commit) begin
                r_head <= r_head + TAG_W'(1);
            end

            if (w_flush_hit) begin
                r_tail  <= flush_tag + TAG_W'(1);
                r_count <= CNT_W'(w_flush_off) + CNT_W'(1) - CNT_W'(w_commit);
            end else begin
                if (w_alloc) begin
                    r_tail <= r_tail + TAG_W'(1);
                end
                r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_commit);
            end

            // Later assignments win: completion, then retire/squash clear, then alloc.
            for (int i = 0; i < int'(SIZE); i++) begin
                if (w_cdb_hit[i] && r_valid[i] && !w_squash[i]) begin
                    r_data[i] <= w_cdb_data[i];
                    r_rdy[i]  <= 1'b1;
                end
                if ((w_commit && (TAG_W'(i) == r_head)) || w_squash[i]) begin
                    r_valid[i] <= 1'b0;
                    r_rdy[i]   <= 1'b0;
                    r_rd[i]    <= '0;
                    r_pc[i]    <= '0;
                    r_data[i]  <= '0;
                end
                if (w_alloc && (TAG_W'(i) == r_tail)) begin
                    r_valid[i] <= 1'b1;
                    r_rdy[i]   <= 1'b0;
                    r_rd[i]    <= alloc_rd;
                    r_pc[i]    <= alloc_pc;
                    r_data[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_port_rob.sv
// Directed bench for multi_port_rob (WIDTH=32, SIZE=16, CDB_PORTS=3).
module tb_multi_port_rob;

    localparam int unsigned W = 32;
    localparam int unsigned S = 16;
    localparam int unsigned P = 3;
    localparam int unsigned T = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           alloc_valid;
    logic [W-1:0]   alloc_pc;
    logic [4:0]     alloc_rd;
    logic           alloc_ready;
    logic [T-1:0]   alloc_tag;
    logic [P-1:0]   cdb_valid;
    logic [P*T-1:0] cdb_tag;
    logic [P*W-1:0] cdb_data;
    logic           commit_valid;
    logic           commit_ready;
    logic [T-1:0]   commit_tag;
    logic [4:0]     commit_rd;
    logic [W-1:0]   commit_data;
    logic [W-1:0]   commit_pc;
    logic           flush;
    logic [T-1:0]   flush_tag;
    logic [T:0]     count;

    int tests = 0;
    int fails = 0;

    multi_port_rob #(.WIDTH(W), .SIZE(S), .CDB_PORTS(P)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_pc(commit_pc),
        .flush(flush), .flush_tag(flush_tag), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid  = 1'b0;
        alloc_pc     = '0;
        alloc_rd     = '0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        cdb_data     = '0;
        commit_ready = 1'b0;
        flush        = 1'b0;
        flush_tag    = '0;
    endtask

    task automatic cdb(input int p, input logic [T-1:0] tag, input logic [W-1:0] data);
        cdb_valid[p]       = 1'b1;
        cdb_tag[p*T +: T]  = tag;
        cdb_data[p*W +: W] = data;
    endtask

    initial begin
        logic [T-1:0] et;
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_commit_pc", commit_pc, 32'd0);

        // Fill all 16 entries
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h1000 + 32'(4 * i);
            alloc_rd    = 5'(i + 1);
            #1;
            chk("fill_tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
        tick();
        chk("full_count_hold", 32'(count), 32'd16);
        chk("full_tail_wrap", 32'(alloc_tag), 32'd0);

        // Two ports hit tag 3; port 2 wins
        idle();
        cdb(0, 4'd3, 32'hAA);
        cdb(2, 4'd3, 32'hBB);
        tick();

        // Head completes while regfile stalls
        idle();
        cdb(0, 4'd0, 32'h10);
        tick();
        idle();
        chk("stall_cv", 32'(commit_valid), 32'd1);
        chk("stall_tag", 32'(commit_tag), 32'd0);
        chk("stall_data", commit_data, 32'h10);
        chk("stall_pc", commit_pc, 32'h1000);
        chk("stall_rd", 32'(commit_rd), 32'd1);
        tick();
        chk("stall_cv_hold", 32'(commit_valid), 32'd1);
        chk("stall_count", 32'(count), 32'd16);
        commit_ready = 1'b1;
        tick();
        chk("c0_count", 32'(count), 32'd15);
        chk("c0_head", 32'(commit_tag), 32'd1);
        chk("c0_cv_next", 32'(commit_valid), 32'd0);
        chk("c0_pc_next", commit_pc, 32'h1004);
        cdb(0, 4'd1, 32'h11);
        cdb(1, 4'd2, 32'h22);
        tick();
        idle();
        commit_ready = 1'b1;
        chk("c1_cv", 32'(commit_valid), 32'd1);
        chk("c1_data", commit_data, 32'h11);
        tick();
        chk("c2_tag", 32'(commit_tag), 32'd2);
        chk("c2_data", commit_data, 32'h22);
        tick();
        chk("c3_tag", 32'(commit_tag), 32'd3);
        chk("c3_data_port2_wins", commit_data, 32'hBB);
        chk("c3_rd", 32'(commit_rd), 32'd4);
        tick();
        chk("c4_cv", 32'(commit_valid), 32'd0);
        chk("c4_count", 32'(count), 32'd12);
        idle();

        // Wrap: reuse tags 0..3
        for (int j = 0; j < 4; j++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h2000 + 32'(4 * j);
            alloc_rd    = 5'(20 + j);
            #1;
            chk("wrap_tag", 32'(alloc_tag), 32'(j));
            tick();
        end
        idle();
        chk("wrap_count", 32'(count), 32'd16);
        for (int k = 0; k < 16; k++) begin
            idle();
            et = 4'((4 + k) % 16);
            cdb(k % 3, et, 32'h100 + 32'(et));
            tick();
        end
        idle();
        commit_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            et = 4'((4 + k) % 16);
            chk("order_cv", 32'(commit_valid), 32'd1);
            chk("order_tag", 32'(commit_tag), 32'(et));
            chk("order_data", commit_data, 32'h100 + 32'(et));
            chk("order_pc", commit_pc, (et < 4) ? 32'h2000 + 32'(4 * et) : 32'h1000 + 32'(4 * et));
            tick();
        end
        idle();
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_cv", 32'(commit_valid), 32'd0);
        chk("drain_data", commit_data, 32'd0);
        chk("drain_tail", 32'(alloc_tag), 32'd4);

        // Partial flush with same-cycle commit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h3000 + 32'(4 * i);
            alloc_rd    = 5'(i);
            tick();
        end
        idle();
        cdb(0, 4'd0, 32'h50);
        tick();
        idle();
        flush        = 1'b1;
        flush_tag    = 4'd2;
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        alloc_pc     = 32'hDEAD;
        cdb(0, 4'd1, 32'h51);
        cdb(1, 4'd5, 32'h55);
        #1;
        chk("fl_alloc_blocked", 32'(alloc_ready), 32'd0);
        chk("fl_commit_head", 32'(commit_valid), 32'd1);
        tick();
        idle();
        chk("fl_count", 32'(count), 32'd2);
        chk("fl_tail", 32'(alloc_tag), 32'd3);
        chk("fl_survivor_cv", 32'(commit_valid), 32'd1);
        chk("fl_survivor_tag", 32'(commit_tag), 32'd1);
        chk("fl_survivor_data", commit_data, 32'h51);
        commit_ready = 1'b1;
        tick();
        idle();
        chk("fl_c1_count", 32'(count), 32'd1);
        chk("fl_c1_head", 32'(commit_tag), 32'd2);
        chk("fl_c1_cv", 32'(commit_valid), 32'd0);
        for (int j = 0; j < 3; j++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h4000 + 32'(4 * j);
            alloc_rd    = 5'(10 + j);
            #1;
            chk("fl_realloc_tag", 32'(alloc_tag), 32'(3 + j));
            tick();
        end
        idle();
        chk("fl_realloc_count", 32'(count), 32'd4);
        cdb(0, 4'd2, 32'h62);
        cdb(1, 4'd3, 32'h63);
        cdb(2, 4'd4, 32'h64);
        tick();
        idle();
        commit_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("fl_commit_tag", 32'(commit_tag), 32'(2 + j));
            chk("fl_commit_data", commit_data, 32'h62 + 32'(j));
            tick();
        end
        idle();
        chk("fl_tag5_dropped_cv", 32'(commit_valid), 32'd0);
        chk("fl_tag5_head", 32'(commit_tag), 32'd5);
        chk("fl_tag5_data", commit_data, 32'd0);
        chk("fl_tag5_pc", commit_pc, 32'h4008);
        chk("fl_end_count", 32'(count), 32'd1);

        // Flush naming an unoccupied tag only blocks alloc
        flush       = 1'b1;
        flush_tag   = 4'd10;
        alloc_valid = 1'b1;
        #1;
        chk("nofl_alloc_blocked", 32'(alloc_ready), 32'd0);
        tick();
        idle();
        chk("nofl_count", 32'(count), 32'd1);
        chk("nofl_tail", 32'(alloc_tag), 32'd6);

        // Reset overrides alloc, CDB and commit on the same edge
        cdb(0, 4'd5, 32'h77);
        tick();
        idle();
        chk("pre_rst_cv", 32'(commit_valid), 32'd1);
        rst          = 1'b1;
        alloc_valid  = 1'b1;
        alloc_pc     = 32'h5000;
        alloc_rd     = 5'd9;
        commit_ready = 1'b1;
        cdb(1, 4'd6, 32'h99);
        tick();
        chk("mid_rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("mid_rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_cv", 32'(commit_valid), 32'd0);
        chk("mid_rst_tag", 32'(commit_tag), 32'd0);
        chk("mid_rst_data", commit_data, 32'd0);
        chk("mid_rst_pc", commit_pc, 32'd0);
        chk("mid_rst_rd", 32'(commit_rd), 32'd0);
        rst = 1'b0;
        idle();
        tick();
        chk("post_rst_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
